i2c_cfg_master: RTL and testbench
=================================

Name: i2c_cfg_master

Overview:
Parametrised I2C write-only configuration master for codec and peripheral register setup, such as the WM8731 audio codec. It walks an external register table of NUM_REGS entries and writes each entry as one I2C frame: START, device address with W, PAYLOAD_BYTES data bytes, STOP. It checks every ACK and retries a NACKed frame up to MAX_RETRY times. It sits between the board-level bring-up sequencer and the open-drain I2C pads.

Parameters:
CLK_DIV, 125, clk cycles per SCL quarter-period (SCL period = 4*CLK_DIV); must be >= 2
NUM_REGS, 9, number of table entries written per run (1..255)
PAYLOAD_BYTES, 2, data bytes per frame after the address byte (1..4)
DEV_ADDR, 7'h1A, 7-bit slave address
MAX_RETRY, 3, extra attempts per entry after a NACK (0..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins a run at entry 0
cfg_idx  out  8  table index currently requested
cfg_data  in  8*PAYLOAD_BYTES  entry for cfg_idx; MSB byte is sent first; sampled once per attempt in START
busy  out  1  high from accepted start until done or err
done  out  1  one-cycle pulse after the last entry is ACKed
err  out  1  sticky; set on retry exhaustion; cleared by next accepted start
err_idx  out  8  entry that failed
i2c_sclk  out  1  SCL (push-pull, idle 1)
sda_oe  out  1  1 = pull SDA low, 0 = release
sda_i  in  1  SDA pad readback

Behaviour:
- Reset values (async, reset=0): state IDLE; i2c_sclk=1, sda_oe=0, busy=0, done=0, err=0, err_idx=0, cfg_idx=0; all counters 0. Reset mid-frame releases the bus immediately; no STOP is generated.
- Quarter tick q: one-clk pulse every CLK_DIV clks, free-running only while busy. The phase counter qp (0..3) advances on q.
- Bit slot (4 quarters): qp0 SCL=0 and SDA updated; qp1 SCL=0; qp2 SCL=1; qp3 SCL=1. SDA changes only at qp0.
- ACK slot: same timing with sda_oe=0. sda_i is sampled on the q that ends qp2. A sample of 0 is ACK; 1 is NACK.
- FSM states and transitions:
  - IDLE: on start, load idx=0, retry=0, clear err, then go to START. start while busy is ignored.
  - START: SCL=1 with SDA released for 2 quarters, then SDA low for 2 quarters. Latch shift register = {DEV_ADDR,1'b0, cfg_data}. Go to BIT.
  - BIT: send 8 bits MSB-first, then go to ACK.
  - ACK: on NACK, go to STOP with a fail flag. On ACK, go to BIT if bytes remain, otherwise go to STOP.
  - STOP: qp0 SCL=0 SDA low; qp1 SCL=1; qp2/qp3 SDA released. Then go to GAP.
  - GAP: bus idle for 4 quarters.
    - On a fail flag with retry < MAX_RETRY: retry++ and go to START with the same idx.
    - On a fail flag with retry exhausted: set err, err_idx=idx, go to IDLE.
    - Otherwise, if idx=NUM_REGS-1: pulse done and go to IDLE.
    - Otherwise: idx++, retry=0, go to START.
- Frame length (no NACK): 4 START + 36*(1+PAYLOAD_BYTES) + 4 STOP + 4 GAP quarters. With defaults this is 120 quarters = 15000 clks. start to first SDA fall = 2*CLK_DIV+1 clks.
- cfg_idx = idx, stable through a frame. cfg_data must be valid by START entry (combinational table lookup).
- busy falls in the same cycle that done pulses or err sets.
- Widths: idx 8 bits; byte counter log2(PAYLOAD_BYTES+1); bit counter 3 bits; retry 4 bits. No counter wraps within legal parameter ranges.

Decomposition:
- Package i2c_pkg: state enum (IDLE, START, BIT, ACK, STOP, GAP), qp encoding, and the I2C_W=1'b0 constant.
- One sub-module, i2c_qtick: parametrised CLK_DIV divider with enable, producing the q pulse and qp. The FSM stays in i2c_cfg_master.

Test Plan:
- CLK_DIV=4, NUM_REGS=2, the slave model ACKs everything, table {16'h1E00,16'h0C00}, pulse start:
  - bus shows frames 34 1E 00 and 34 0C 00;
  - done pulses once after 240 quarters (960 clks);
  - err=0.
- Slave NACKs the address byte on the first attempt of entry 1, MAX_RETRY=3: entry 1 is resent once and done follows; total time is 3 frames.
- Slave always NACKs entry 0, MAX_RETRY=2: exactly 3 attempts, then err=1, err_idx=0, busy=0, and done never pulses.
- start pulsed again while busy: no effect on frame count or cfg_idx. A start after err clears err and replays from idx 0.
- reset asserted at qp2 of bit 5 of the second byte: i2c_sclk=1 and sda_oe=0 in the same cycle, busy=0; a fresh start sends a clean START.
- Protocol checker across all tests: SDA never changes while SCL=1 except at START/STOP, and SCL high time = 2*CLK_DIV.

Source files
------------

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the I2C configuration master.
//   state_t : frame sequencer states
//   qp_t    : quarter-phase encoding within one SCL bit slot
//   I2C_W   : R/W bit value for a write transfer
// -----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        ACK,
        STOP,
        GAP
    } state_t;

    // qp0/qp1: SCL low, qp2/qp3: SCL high
    typedef enum logic [1:0] {
        QP0,
        QP1,
        QP2,
        QP3
    } qp_t;

    localparam logic I2C_W = 1'b0;

endpackage

// File: rtl/i2c_cfg_master_qtick.sv
// -----------------------------------------------------------------------------
// i2c_qtick
// Quarter-period tick generator. While enabled, q_o pulses for one clk every
// CLK_DIV clks and qp_o (0..3) advances on each pulse. Disabled => held at 0.
//   clk, reset : clock, async active-low reset
//   en_i       : run enable
//   q_o        : one-clk quarter tick
//   qp_o       : current quarter phase
// -----------------------------------------------------------------------------
module i2c_qtick
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    output logic       q_o,
    output logic [1:0] qp_o
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic [1:0]    qp_q;

    assign q_o  = en_i && (cnt_q == CW'(CLK_DIV - 1));
    assign qp_o = qp_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            qp_q  <= QP0;
        end else if (!en_i) begin
            cnt_q <= '0;
            qp_q  <= QP0;
        end else if (q_o) begin
            cnt_q <= '0;
            qp_q  <= qp_q + 2'd1;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_cfg_master.sv
// -----------------------------------------------------------------------------
// i2c_cfg_master
// Write-only I2C configuration master. Walks a NUM_REGS-entry external table,
// sending START, DEV_ADDR+W, PAYLOAD_BYTES data bytes (MSB byte first), STOP
// per entry, with ACK checking and up to MAX_RETRY retries per NACKed frame.
//   clk, reset : clock, async active-low reset
//   start      : one-cycle run request (ignored while busy)
//   cfg_idx    : table index requested; cfg_data : entry for cfg_idx
//   busy/done  : run in progress / one-cycle completion pulse
//   err/err_idx: sticky retry-exhaustion flag / entry that failed
//   i2c_sclk   : SCL (push-pull); sda_oe : 1 pulls SDA low; sda_i : readback
// -----------------------------------------------------------------------------
module i2c_cfg_master
    import i2c_pkg::*;
#(
    parameter int         CLK_DIV       = 125,
    parameter int         NUM_REGS      = 9,
    parameter int         PAYLOAD_BYTES = 2,
    parameter logic [6:0] DEV_ADDR      = 7'h1A,
    parameter int         MAX_RETRY     = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic [7:0]                 cfg_idx,
    input  logic [8*PAYLOAD_BYTES-1:0] cfg_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [7:0]                 err_idx,
    output logic                       i2c_sclk,
    output logic                       sda_oe,
    input  logic                       sda_i
);

    localparam int             SW        = 8 * (PAYLOAD_BYTES + 1);
    localparam int             BW        = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [BW-1:0]  LAST_BYTE = BW'(PAYLOAD_BYTES);
    localparam logic [7:0]     LAST_IDX  = 8'(NUM_REGS - 1);
    localparam logic [3:0]     RETRY_MAX = 4'(MAX_RETRY);

    state_t          state_q, state_d;
    logic [7:0]      idx_q, idx_d;
    logic [3:0]      retry_q, retry_d;
    logic [BW-1:0]   byte_q, byte_d;
    logic [2:0]      bit_q, bit_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic            fail_q, fail_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      erridx_q, erridx_d;
    logic            scl_q, scl_d;
    logic            oe_q, oe_d;

    logic            q;
    logic [1:0]      qp;
    logic            qend;

    i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk   (clk),
        .reset (reset),
        .en_i  (busy_q),
        .q_o   (q),
        .qp_o  (qp)
    );

    assign qend = q && (qp == QP3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            retry_q  <= '0;
            byte_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            fail_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            erridx_q <= '0;
            scl_q    <= 1'b1;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
            byte_q   <= byte_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            fail_q   <= fail_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            erridx_q <= erridx_d;
            scl_q    <= scl_d;
            oe_q     <= oe_d;
        end
    end

    // Sequencer: every non-idle state spans whole 4-quarter slots and
    // advances on the tick that ends qp3.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        retry_d  = retry_q;
        byte_d   = byte_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fail_d   = fail_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        erridx_d = erridx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    retry_d = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (qend) begin
                    shift_d = {DEV_ADDR, I2C_W, cfg_data};
                    byte_d  = '0;
                    bit_d   = '0;
                    fail_d  = 1'b0;
                    state_d = BIT;
                end
            end
            BIT: begin
                if (qend) begin
                    shift_d = {shift_q[SW-2:0], 1'b0};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = ACK;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ACK: begin
                // Sampled at the end of qp2; held stable through qp3.
                if (q && (qp == QP2)) begin
                    fail_d = sda_i;
                end
                if (qend) begin
                    if (fail_q || (byte_q == LAST_BYTE)) begin
                        state_d = STOP;
                    end else begin
                        byte_d  = byte_q + BW'(1);
                        state_d = BIT;
                    end
                end
            end
            STOP: begin
                if (qend) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (qend) begin
                    if (fail_q) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 4'd1;
                            state_d = START;
                        end else begin
                            err_d    = 1'b1;
                            erridx_d = idx_q;
                            busy_d   = 1'b0;
                            state_d  = IDLE;
                        end
                    end else if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        retry_d = '0;
                        state_d = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin levels decoded from state/phase and registered, so the pads are
    // glitch-free and drop to the idle levels directly on reset.
    always_comb begin
        scl_d = 1'b1;
        oe_d  = 1'b0;
        case (state_q)
            START: oe_d = qp[1];
            BIT: begin
                scl_d = qp[1];
                oe_d  = ~shift_q[SW-1];
            end
            ACK:  scl_d = qp[1];
            STOP: begin
                scl_d = (qp != QP0);
                oe_d  = ~qp[1];
            end
            default: begin
                scl_d = 1'b1;
                oe_d  = 1'b0;
            end
        endcase
    end

    assign cfg_idx  = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_idx  = erridx_q;
    assign i2c_sclk = scl_q;
    assign sda_oe   = oe_q;

endmodule

// File: tb/tb_i2c_cfg_master.sv
// -----------------------------------------------------------------------------
// tb_i2c_cfg_master
// Table-driven bench for i2c_cfg_master with CLK_DIV=4, NUM_REGS=2,
// PAYLOAD_BYTES=2, MAX_RETRY=2. A bus decoder/slave model records frames,
// ACKs or NACKs according to the current mode, and checks SCL high time.
// -----------------------------------------------------------------------------
module tb_i2c_cfg_master;

    localparam int CD = 4;
    localparam int NR = 2;
    localparam int PB = 2;
    localparam int MR = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  cfg_idx;
    logic [15:0] cfg_data;
    logic        busy, done, err;
    logic [7:0]  err_idx;
    logic        i2c_sclk, sda_oe, sda_i;

    logic [15:0] tbl0, tbl1;
    logic        slave_pull = 1'b0;
    int          mode = 0;

    int n_chk  = 0;
    int n_fail = 0;

    assign cfg_data = (cfg_idx == 8'd1) ? tbl1 : tbl0;
    assign sda_i    = ~(sda_oe | slave_pull);

    always #5 clk = ~clk;

    i2c_cfg_master #(
        .CLK_DIV       (CD),
        .NUM_REGS      (NR),
        .PAYLOAD_BYTES (PB),
        .DEV_ADDR      (7'h1A),
        .MAX_RETRY     (MR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cfg_idx  (cfg_idx),
        .cfg_data (cfg_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_idx  (err_idx),
        .i2c_sclk (i2c_sclk),
        .sda_oe   (sda_oe),
        .sda_i    (sda_i)
    );

    // ---------------- bus decoder + slave model ----------------
    logic        p_scl = 1'b1, p_sda = 1'b1;
    logic        had_cond = 1'b1, in_ack = 1'b0;
    logic [7:0]  sh = '0;
    logic [31:0] fval = '0;
    logic [7:0]  last_idx = 8'hFF;
    int          bitc = 0, fn = 0, hi_len = 0, attempt = 0, viol = 0;
    logic [31:0] fq_val[$];
    int          fq_n[$];

    // mode 1: NACK address on first attempt of entry 1
    // mode 2: NACK address of entry 0 always; mode 3: of entry 1 always
    function automatic logic nack_now();
        if (fn != 0) return 1'b0;
        case (mode)
            1:       return (cfg_idx == 8'd1) && (attempt == 0);
            2:       return (cfg_idx == 8'd0);
            3:       return (cfg_idx == 8'd1);
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            slave_pull = 1'b0;
            in_ack     = 1'b0;
        end else begin
            if (i2c_sclk && p_scl && (sda_i != p_sda)) begin
                had_cond = 1'b1;
                if (!sda_i) begin
                    bitc = 0; fn = 0; fval = '0;
                    if (cfg_idx == last_idx) attempt++;
                    else begin attempt = 0; last_idx = cfg_idx; end
                end else begin
                    fq_val.push_back(fval);
                    fq_n.push_back(fn);
                end
            end
            if (i2c_sclk && !p_scl) begin
                hi_len   = 0;
                had_cond = 1'b0;
                if (bitc < 8) begin
                    sh = {sh[6:0], sda_i};
                    bitc++;
                end else begin
                    fval = {fval[23:0], sh};
                    fn++;
                    bitc = 0;
                end
            end
            if (i2c_sclk) hi_len++;
            if (!i2c_sclk && p_scl) begin
                if (!had_cond && (hi_len != 2*CD)) begin
                    viol++;
                    $display("FAIL scl_high_time got %0d want %0d at %0t", hi_len, 2*CD, $time);
                end
                if (in_ack) begin
                    slave_pull = 1'b0;
                    in_ack     = 1'b0;
                end else if (bitc == 8) begin
                    in_ack     = 1'b1;
                    slave_pull = !nack_now();
                end
            end
        end
        p_scl = i2c_sclk;
        p_sda = sda_i;
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int              mode;
        logic [15:0]     t0, t1;
        int              mid_start;   // cycle to re-pulse start while busy (0 = none)
        int              exp_cyc;     // clks from start edge to done/err
        int              exp_done;    // number of done pulses
        logic            exp_err;
        logic [7:0]      exp_eidx;
        logic [7:0]      exp_idx;
        int              nf;
        logic [0:3][31:0] fv;
        logic [0:3][2:0]  fnn;
    } vec_t;

    vec_t v[5];

    task automatic run(input vec_t t, input string nm);
        int   cyc;
        int   dones;
        int   base;
        logic seen;
        mode = t.mode;
        tbl0 = t.t0;
        tbl1 = t.t1;
        base = fq_val.size();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        chk({nm, ":busy_after_start"}, busy, 1);
        chk({nm, ":err_after_start"}, err, 0);
        chk({nm, ":idx_after_start"}, cfg_idx, 0);
        seen = 1'b0;
        while (!seen && cyc < 6000) begin
            @(posedge clk); #1;
            cyc++;
            start = (t.mid_start != 0 && cyc == t.mid_start);
            if (t.mid_start != 0 && cyc == t.mid_start + 2) begin
                chk({nm, ":idx_after_busy_start"}, cfg_idx, 1);
                chk({nm, ":busy_after_busy_start"}, busy, 1);
            end
            if (done || err) seen = 1'b1;
        end
        start = 1'b0;
        chk({nm, ":finish_cycle"}, cyc, t.exp_cyc);
        chk({nm, ":busy_at_finish"}, busy, 0);
        chk({nm, ":err"}, err, t.exp_err);
        chk({nm, ":err_idx"}, err_idx, t.exp_eidx);
        chk({nm, ":cfg_idx_end"}, cfg_idx, t.exp_idx);
        dones = int'(done);
        repeat (20) begin
            @(posedge clk); #1;
            dones += int'(done);
        end
        chk({nm, ":done_pulses"}, dones, t.exp_done);
        chk({nm, ":err_sticky"}, err, t.exp_err);
        chk({nm, ":frame_count"}, fq_val.size() - base, t.nf);
        for (int i = 0; i < t.nf; i++) begin
            if (base + i < fq_val.size()) begin
                chk($sformatf("%s:frame%0d_bytes", nm, i), fq_val[base+i], t.fv[i]);
                chk($sformatf("%s:frame%0d_len", nm, i), fq_n[base+i], 32'(t.fnn[i]));
            end
        end
    endtask

    initial begin
        int cyc;
        v[0] = '{0, 16'h1E00, 16'h0C00, 0,   960,  1, 1'b0, 8'd0, 8'd1, 2,
                 {32'h341E00, 32'h340C00, 32'h0, 32'h0}, {3'd3, 3'd3, 3'd0, 3'd0}};
        v[1] = '{1, 16'h1E00, 16'h0C00, 0,   1152, 1, 1'b0, 8'd0, 8'd1, 3,
                 {32'h341E00, 32'h34, 32'h340C00, 32'h0}, {3'd3, 3'd1, 3'd3, 3'd0}};
        v[2] = '{2, 16'h1E00, 16'h0C00, 0,   576,  0, 1'b1, 8'd0, 8'd0, 3,
                 {32'h34, 32'h34, 32'h34, 32'h0}, {3'd1, 3'd1, 3'd1, 3'd0}};
        v[3] = '{3, 16'h1E00, 16'h0C00, 0,   1056, 0, 1'b1, 8'd1, 8'd1, 4,
                 {32'h341E00, 32'h34, 32'h34, 32'h34}, {3'd3, 3'd1, 3'd1, 3'd1}};
        v[4] = '{0, 16'hA55A, 16'h0F3C, 700, 960,  1, 1'b0, 8'd1, 8'd1, 2,
                 {32'h34A55A, 32'h340F3C, 32'h0, 32'h0}, {3'd3, 3'd3, 3'd0, 3'd0}};

        reset = 1'b0;
        start = 1'b0;
        tbl0  = 16'h1E00;
        tbl1  = 16'h0C00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset:scl", i2c_sclk, 1);
        chk("reset:sda_oe", sda_oe, 0);
        chk("reset:busy", busy, 0);
        chk("reset:done", done, 0);
        chk("reset:err", err, 0);
        chk("reset:err_idx", err_idx, 0);
        chk("reset:cfg_idx", cfg_idx, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++) begin
            run(v[i], $sformatf("vec%0d", i));
        end

        // Reset at qp2 of data bit 5 of the second byte (quarter 62).
        mode = 0;
        tbl0 = 16'h0000;
        tbl1 = 16'h0C00;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (cyc < 62*CD + 2) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("midreset:scl_before", i2c_sclk, 1);
        chk("midreset:oe_before", sda_oe, 1);
        reset = 1'b0;
        #1;
        chk("midreset:scl", i2c_sclk, 1);
        chk("midreset:sda_oe", sda_oe, 0);
        chk("midreset:busy", busy, 0);
        chk("midreset:cfg_idx", cfg_idx, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        run(v[0], "post_reset");

        chk("protocol:violations", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
